// File: rtl/pipe_pkg.sv
// Shared constants for the 1:2 buffered demultiplexer: default payload width
// and the in_sel encoding that picks the destination stream.
package pipe_pkg;

  localparam int WIDTH_DEFAULT = 64;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : pipe_pkg

// File: rtl/fifo_sync_64.sv
// Small synchronous FIFO whose head word is held in its own register, so the
// output data comes straight from a flop and stays put while the consumer stalls.
module fifo_sync_64
  import pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_rd_next;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push    = push && !full;
  assign w_pop     = pop && !empty;
  assign w_rd_next = r_rd_ptr + PW'(1);
  assign count     = r_count;
  assign head      = r_head;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Head tracks the next oldest entry; a push into an empty (or just-drained)
  // FIFO lands here directly, giving one cycle of latency with no bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (w_pop) begin
      if (r_count > CW'(1)) r_head <= r_mem[w_rd_next];
      else if (w_push)      r_head <= din;
    end else if (w_push && empty) begin
      r_head <= din;
    end
  end

endmodule : fifo_sync_64

// File: rtl/demux1_2_64_buf.sv
// 1:2 demultiplexer with an independent FIFO per output; acceptance depends
// only on the selected FIFO, so a stall on one output never blocks the other.
module demux1_2_64_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [WIDTH-1:0]       a_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [WIDTH-1:0]       b_data,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);

  logic w_full_a, w_full_b;
  logic w_empty_a, w_empty_b;
  logic w_sel_full;
  logic w_xfer;
  logic w_push_a, w_push_b;

  assign w_sel_full = (in_sel == SEL_B) ? w_full_b : w_full_a;
  assign in_ready   = !rst_n || !w_sel_full;
  assign w_xfer     = rst_n && in_valid && in_ready;
  assign w_push_a   = w_xfer && (in_sel == SEL_A);
  assign w_push_b   = w_xfer && (in_sel == SEL_B);

  assign a_valid = !w_empty_a;
  assign b_valid = !w_empty_b;

  fifo_sync_64 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push_a),
    .pop   (a_valid && a_ready),
    .din   (in_data),
    .full  (w_full_a),
    .empty (w_empty_a),
    .count (a_count),
    .head  (a_data)
  );

  fifo_sync_64 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push_b),
    .pop   (b_valid && b_ready),
    .din   (in_data),
    .full  (w_full_b),
    .empty (w_empty_b),
    .count (b_count),
    .head  (b_data)
  );

endmodule : demux1_2_64_buf

// File: tb/tb_demux1_2_64_buf.sv
// Bench for demux1_2_64_buf: directed scenarios plus random traffic, all
// checked each cycle against a queue-based model of the two output streams.
module tb_demux1_2_64_buf;

  localparam int WIDTH = 64;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sel = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             a_ready = 1'b0;
  logic             b_ready = 1'b0;
  logic             in_ready;
  logic             a_valid, b_valid;
  logic [WIDTH-1:0] a_data, b_data;
  logic [CW-1:0]    a_count, b_count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] log_a[$];

  always #5 clk = ~clk;

  demux1_2_64_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, then advance
  // the model by the transfers that the next rising edge will perform.
  task automatic cycle(input logic v, input logic s, input logic [63:0] d,
                       input logic ar, input logic br, output bit acc);
    bit room, pa, pb;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    #1;
    room = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    check_eq("in_ready", 64'(in_ready), 64'(room));
    check_eq("a_valid",  64'(a_valid),  64'(qa.size() != 0));
    check_eq("b_valid",  64'(b_valid),  64'(qb.size() != 0));
    check_eq("a_count",  64'(a_count),  64'(qa.size()));
    check_eq("b_count",  64'(b_count),  64'(qb.size()));
    if (qa.size() != 0) check_eq("a_data", a_data, qa[0]);
    if (qb.size() != 0) check_eq("b_data", b_data, qb[0]);
    acc = v && room;
    pa  = ar && (qa.size() != 0);
    pb  = br && (qb.size() != 0);
    if (pa) log_a.push_back(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (s) qb.push_back(d);
      else   qa.push_back(d);
    end
  endtask

  // Asynchronous reset asserted between edges, held across one rising edge
  // with a word offered, then released.
  task automatic reset_pulse();
    @(negedge clk);
    check_eq("pre_rst_a_count", 64'(a_count), 64'(qa.size()));
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hDEAD; a_ready = 1'b1; b_ready = 1'b1;
    #1;
    check_eq("rst_a_valid",  64'(a_valid),  64'd0);
    check_eq("rst_b_valid",  64'(b_valid),  64'd0);
    check_eq("rst_a_count",  64'(a_count),  64'd0);
    check_eq("rst_b_count",  64'(b_count),  64'd0);
    check_eq("rst_a_data",   a_data,        64'd0);
    check_eq("rst_b_data",   b_data,        64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    qa.delete(); qb.delete();
    @(negedge clk);
    check_eq("rst_hold_a_count", 64'(a_count), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    logic [63:0] words[10];
    int idx;

    reset_pulse();

    // Ordering within A, drained with a_ready high
    cycle(1'b1, 1'b0, 64'h1111, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 64'h2222, 1'b0, 1'b0, acc);
    repeat (3) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, acc);

    // A full must not block B
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 64'hA000 + 64'(i), 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 64'hBAD0, 1'b0, 1'b0, acc);
    check_eq("full_a_reject", 64'(acc), 64'd0);
    cycle(1'b1, 1'b1, 64'hBEEF, 1'b0, 1'b0, acc);
    check_eq("b_accept", 64'(acc), 64'd1);
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, acc);

    // Full A with a simultaneous read: write refused, count drops by one
    cycle(1'b1, 1'b0, 64'hBAD1, 1'b1, 1'b0, acc);
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, acc);
    repeat (4) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, acc);

    // Wrap-around: 10 words into A with a_ready toggling
    log_a.delete();
    for (int i = 0; i < 10; i++) words[i] = {$urandom, $urandom};
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      cycle(idx < 10, 1'b0, (idx < 10) ? words[idx] : 64'h0, c[0], 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("wrap_count", 64'(log_a.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      if (i < log_a.size()) check_eq("wrap_order", log_a[i], words[i]);

    // Interleaved traffic with both outputs always ready
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, i[0], 64'h5000 + 64'(i), 1'b1, 1'b1, acc);
      check_eq("ilv_accept", 64'(acc), 64'd1);
    end
    repeat (2) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, acc);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom), {$urandom, $urandom},
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, acc);

    // Reset mid-stream with two words parked in A
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, acc);
    cycle(1'b1, 1'b0, 64'hC001, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 64'hC002, 1'b0, 1'b0, acc);
    reset_pulse();
    repeat (3) cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux1_2_64_buf
